// File: rtl/mb_reconstruct.sv
// Macroblock reconstruction: adds signed residuals to prediction samples one row per
// clock, clamps to 0..255, counts clipped samples and strobes the finished block out.
module mb_reconstruct #(
   parameter int MB_SIZE_L = 8,
   parameter int MB_SIZE_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] mbnumber,
   input  logic [7:0]  pred    [MB_SIZE_L*MB_SIZE_W],
   input  logic [8:0]  resid   [MB_SIZE_L*MB_SIZE_W],
   output logic [7:0]  reconst [MB_SIZE_L*MB_SIZE_W],
   output logic [31:0] mbnumber_out,
   output logic        save_en,
   output logic        busy,
   output logic        done,
   output logic [6:0]  clip_count,
   output logic        overrun
);

   localparam int N  = MB_SIZE_L * MB_SIZE_W;
   localparam int RW = (MB_SIZE_L > 1) ? $clog2(MB_SIZE_L) : 1;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [RW-1:0] LAST_ROW = RW'(MB_SIZE_L - 1);
   localparam logic [7:0]    CLIP_MAX = 8'(N);

   typedef enum logic [1:0] {IDLE, CALC, SAVE, DONE} state_t;

   state_t      state_q, state_d;
   logic [RW-1:0] row_q, row_d;
   logic [6:0]  clip_count_q, clip_count_d;
   logic [31:0] mbnumber_out_q, mbnumber_out_d;
   logic        save_en_q, save_en_d;
   logic        done_q, done_d;
   logic        overrun_q, overrun_d;
   logic [7:0]  pred_q    [N];
   logic [7:0]  pred_d    [N];
   logic [8:0]  resid_q   [N];
   logic [8:0]  resid_d   [N];
   logic [7:0]  reconst_q [N];
   logic [7:0]  reconst_d [N];

   logic [IW-1:0]        row_base;
   logic [7:0]           lane_val [MB_SIZE_W];
   logic [MB_SIZE_W-1:0] lane_clip;
   logic [6:0]           row_clips;
   logic [7:0]           clip_sum;

   assign row_base = IW'(row_q) * IW'(MB_SIZE_W);

   // One lane per column; sum fits 10-bit signed, so bit 9 = negative, bit 8 = above 255.
   for (genvar gi = 0; gi < MB_SIZE_W; gi++) begin : g_lane
      logic [IW-1:0]      idx;
      logic signed [9:0]  sum;
      assign idx = row_base + IW'(gi);
      assign sum = $signed({2'b00, pred_q[idx]}) + $signed({resid_q[idx][8], resid_q[idx]});
      assign lane_val[gi]  = sum[9] ? 8'd0 : (sum[8] ? 8'hFF : sum[7:0]);
      assign lane_clip[gi] = sum[9] | sum[8];
   end

   always_comb begin
      row_clips = '0;
      for (int j = 0; j < MB_SIZE_W; j++) begin
         row_clips = row_clips + 7'(lane_clip[j]);
      end
      clip_sum = {1'b0, clip_count_q} + {1'b0, row_clips};
   end

   always_comb begin
      state_d        = state_q;
      row_d          = row_q;
      clip_count_d   = clip_count_q;
      mbnumber_out_d = mbnumber_out_q;
      pred_d         = pred_q;
      resid_d        = resid_q;
      reconst_d      = reconst_q;
      save_en_d      = (state_q == SAVE);
      done_d         = (state_q == DONE);
      overrun_d      = overrun_q | (start && (state_q != IDLE));
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d        = CALC;
               row_d          = '0;
               clip_count_d   = '0;
               mbnumber_out_d = mbnumber;
               pred_d         = pred;
               resid_d        = resid;
            end
         end
         CALC: begin
            for (int j = 0; j < MB_SIZE_W; j++) begin
               reconst_d[row_base + IW'(j)] = lane_val[j];
            end
            clip_count_d = (clip_sum > CLIP_MAX) ? CLIP_MAX[6:0] : clip_sum[6:0];
            if (row_q == LAST_ROW) begin
               state_d = SAVE;
               row_d   = '0;
            end else begin
               row_d = row_q + 1'b1;
            end
         end
         SAVE:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         row_q          <= '0;
         clip_count_q   <= '0;
         mbnumber_out_q <= '0;
         save_en_q      <= 1'b0;
         done_q         <= 1'b0;
         overrun_q      <= 1'b0;
         for (int k = 0; k < N; k++) begin
            pred_q[k]    <= '0;
            resid_q[k]   <= '0;
            reconst_q[k] <= '0;
         end
      end else begin
         state_q        <= state_d;
         row_q          <= row_d;
         clip_count_q   <= clip_count_d;
         mbnumber_out_q <= mbnumber_out_d;
         save_en_q      <= save_en_d;
         done_q         <= done_d;
         overrun_q      <= overrun_d;
         pred_q         <= pred_d;
         resid_q        <= resid_d;
         reconst_q      <= reconst_d;
      end
   end

   assign reconst      = reconst_q;
   assign mbnumber_out = mbnumber_out_q;
   assign save_en      = save_en_q;
   assign done         = done_q;
   assign busy         = (state_q != IDLE);
   assign clip_count   = clip_count_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_mb_reconstruct.sv
// Directed bench for mb_reconstruct: uniform, saturating, mixed, overrun, reset-abort
// and back-to-back blocks, each with hand-computed expected samples and timing.
module tb_mb_reconstruct;

   localparam int L = 8;
   localparam int W = 8;
   localparam int N = L * W;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] mbnumber = '0;
   logic [7:0]  pred    [N];
   logic [8:0]  resid   [N];
   logic [7:0]  reconst [N];
   logic [31:0] mbnumber_out;
   logic        save_en, busy, done, overrun;
   logic [6:0]  clip_count;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int save_cnt = 0, save_cyc = 0, done_cnt = 0, done_cyc = 0;
   logic [7:0]  snap [N];
   logic [31:0] snap_mb;

   mb_reconstruct #(.MB_SIZE_L(L), .MB_SIZE_W(W)) dut (
      .clk(clk), .reset(reset), .start(start), .mbnumber(mbnumber),
      .pred(pred), .resid(resid), .reconst(reconst), .mbnumber_out(mbnumber_out),
      .save_en(save_en), .busy(busy), .done(done), .clip_count(clip_count),
      .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Record strobe timing and the block contents seen while save_en is high.
   always @(negedge clk) begin
      if (save_en) begin
         save_cnt <= save_cnt + 1;
         save_cyc <= cyc;
         snap     <= reconst;
         snap_mb  <= mbnumber_out;
      end
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fill(input int p, input int r, input int p0, input int r0);
      for (int k = 0; k < N; k++) begin
         pred[k]  = (k < W) ? 8'(p0) : 8'(p);
         resid[k] = (k < W) ? 9'(r0) : 9'(r);
      end
   endtask

   function automatic int count_bad(input logic [7:0] arr [N], input logic [7:0] e0,
                                    input logic [7:0] e);
      int bad = 0;
      for (int k = 0; k < N; k++) begin
         if (arr[k] !== ((k < W) ? e0 : e)) bad++;
      end
      return bad;
   endfunction

   task automatic pulse_start(output int t0);
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      t0 = cyc;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (done !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("done_timeout", done, 1'b1);
   endtask

   task automatic finish_block(input string tag, input int t0, input int sbase, input int dbase,
                               input logic [7:0] e0, input logic [7:0] e,
                               input logic [6:0] eclip, input logic [31:0] emb);
      wait_done(20);
      @(posedge clk);
      #1;
      check({tag, "_save_cnt"}, save_cnt - sbase, 1);
      check({tag, "_done_cnt"}, done_cnt - dbase, 1);
      check({tag, "_save_cyc"}, save_cyc - t0, 9);
      check({tag, "_done_cyc"}, done_cyc - t0, 10);
      check({tag, "_snap_bad"}, count_bad(snap, e0, e), 0);
      check({tag, "_snap_mb"}, snap_mb, emb);
      check({tag, "_reconst_bad"}, count_bad(reconst, e0, e), 0);
      check({tag, "_clip"}, clip_count, eclip);
      check({tag, "_mb_out"}, mbnumber_out, emb);
      check({tag, "_busy_after"}, busy, 1'b0);
      $display("block %s: row0=%0d rest=%0d clip=%0d mb=%h", tag, reconst[0], reconst[N-1],
               clip_count, mbnumber_out);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, sb, db, s1;
      fill(0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_save_en", save_en, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_clip", clip_count, 7'd0);
      check("rst_mb_out", mbnumber_out, 32'd0);
      check("rst_reconst_bad", count_bad(reconst, 8'd0, 8'd0), 0);
      reset = 1'b0;

      // 100 + 20 = 120; inputs scrambled right after capture must not matter
      fill(100, 20, 100, 20);
      mbnumber = 32'h1234_5678;
      sb = save_cnt; db = done_cnt;
      pulse_start(t0);
      check("a_busy", busy, 1'b1);
      @(posedge clk);
      #1 fill(0, 0, 0, 0);
      mbnumber = 32'hDEAD_BEEF;
      finish_block("a", t0, sb, db, 8'd120, 8'd120, 7'd0, 32'h1234_5678);

      // 250 + 100 = 350 -> 255, every sample clipped
      fill(250, 100, 250, 100);
      mbnumber = 32'h0000_0001;
      sb = save_cnt; db = done_cnt;
      pulse_start(t0);
      finish_block("b", t0, sb, db, 8'd255, 8'd255, 7'd64, 32'h0000_0001);

      // 5 - 200 = -195 -> 0, every sample clipped
      fill(5, -200, 5, -200);
      mbnumber = 32'h0000_0002;
      sb = save_cnt; db = done_cnt;
      pulse_start(t0);
      finish_block("c", t0, sb, db, 8'd0, 8'd0, 7'd64, 32'h0000_0002);

      // row 0: 255 + 1 -> 255 clipped (8); other rows 0
      fill(0, 0, 255, 1);
      mbnumber = 32'h0010_0020;
      sb = save_cnt; db = done_cnt;
      pulse_start(t0);
      finish_block("d", t0, sb, db, 8'd255, 8'd0, 7'd8, 32'h0010_0020);

      // second start at edge 4 is ignored but flags overrun; 60 + 3 = 63
      fill(60, 3, 60, 3);
      mbnumber = 32'h0000_0005;
      sb = save_cnt; db = done_cnt;
      pulse_start(t0);
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      fill(200, 0, 200, 0);
      mbnumber = 32'h0000_0006;
      @(posedge clk);
      #1 start = 1'b0;
      finish_block("e", t0, sb, db, 8'd63, 8'd63, 7'd0, 32'h0000_0005);
      check("e_overrun", overrun, 1'b1);

      // reset at edge 5 of CALC aborts the block
      fill(10, 10, 10, 10);
      mbnumber = 32'h0000_0009;
      pulse_start(t0);
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("f_rst_busy", busy, 1'b0);
      check("f_rst_save_en", save_en, 1'b0);
      check("f_rst_reconst_bad", count_bad(reconst, 8'd0, 8'd0), 0);
      check("f_rst_overrun", overrun, 1'b0);
      check("f_rst_clip", clip_count, 7'd0);
      sb = save_cnt; db = done_cnt;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      check("f_no_save", save_cnt - sb, 0);
      check("f_no_done", done_cnt - db, 0);
      check("f_idle_busy", busy, 1'b0);
      fill(7, 8, 7, 8);
      mbnumber = 32'h0000_000A;
      sb = save_cnt; db = done_cnt;
      pulse_start(t0);
      finish_block("f2", t0, sb, db, 8'd15, 8'd15, 7'd0, 32'h0000_000A);

      // back-to-back: restart sampled on the edge that ends the done cycle
      fill(1, 1, 1, 1);
      mbnumber = 32'h0000_0007;
      pulse_start(t0);
      wait_done(20);
      start = 1'b1;
      s1 = save_cyc;
      fill(3, 0, 3, 0);
      mbnumber = 32'h0000_0008;
      @(posedge clk);
      #1 start = 1'b0;
      t1 = cyc;
      sb = save_cnt; db = done_cnt;
      check("g_first_save_cyc", s1 - t0, 9);
      finish_block("g2", t1, sb, db, 8'd3, 8'd3, 7'd0, 32'h0000_0008);
      check("g_save_gap", save_cyc - s1, 11);
      check("g_overrun", overrun, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
